// File: rtl/sync_barrier_ctrl.sv
// Barrier synchronisation responder for N_CORES processor cores.
// Collects per-core barrier arrivals. Once every participating core has
// arrived, or the round has timed out, the arrived cores are released
// together with a one-cycle sync_ready strobe.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   core_mask             participating cores, sampled at the first arrival of a round
//   timeout_cycles        round timeout in cycles (0 disables the timeout)
//   sync_enable           per-core arrival strobe
//   sync_barrier          per-core barrier ID, core i on bits [i*W +: W]
//   sync_ready            per-core release strobe (one cycle)
//   busy                  a round is in progress
//   last_barrier_id       ID of the most recent release
//   release_count         number of releases (wraps)
//   err_clear             clears the sticky error flags
//   err_mismatch          sticky: released cores carried differing IDs
//   err_dup               sticky: a core arrived twice in one round
//   err_timeout           sticky: a round timed out
module sync_barrier_ctrl #(
    parameter int unsigned N_CORES            = 4,
    parameter int unsigned SYNC_BARRIER_WIDTH = 8,
    parameter int unsigned TIMEOUT_WIDTH      = 16,
    parameter int unsigned COUNT_WIDTH        = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_CORES-1:0]                    core_mask,
    input  logic [TIMEOUT_WIDTH-1:0]              timeout_cycles,
    input  logic [N_CORES-1:0]                    sync_enable,
    input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier,
    output logic [N_CORES-1:0]                    sync_ready,
    output logic                                  busy,
    output logic [SYNC_BARRIER_WIDTH-1:0]         last_barrier_id,
    output logic [COUNT_WIDTH-1:0]                release_count,
    input  logic                                  err_clear,
    output logic                                  err_mismatch,
    output logic                                  err_dup,
    output logic                                  err_timeout
);

    localparam int unsigned IW  = SYNC_BARRIER_WIDTH;
    localparam int unsigned TW1 = TIMEOUT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [N_CORES-1:0]        arrived_q, arrived_d;
    logic [N_CORES-1:0]        mask_q, mask_d;
    logic [N_CORES*IW-1:0]     ids_q, ids_d;
    logic [TIMEOUT_WIDTH-1:0]  tcnt_q, tcnt_d;

    logic [N_CORES-1:0]        ready_d;
    logic                      busy_d;
    logic [IW-1:0]             last_id_d;
    logic [COUNT_WIDTH-1:0]    count_d;
    logic                      err_mismatch_d, err_dup_d, err_timeout_d;

    logic [N_CORES-1:0]        start_hits_c;
    logic [N_CORES-1:0]        load_c;
    logic                      all_arrived_c;
    logic                      timeout_hit_c;
    logic                      set_mis_c, set_dup_c, set_to_c;
    logic [IW-1:0]             first_id_c;
    logic                      first_found_c;
    logic                      mismatch_c;

    // Round start condition and completion / timeout detection
    assign start_hits_c  = sync_enable & core_mask;
    assign all_arrived_c = (arrived_q == mask_q);
    // Widened compare so a maximal timeout_cycles cannot alias on counter wrap
    assign timeout_hit_c = (timeout_cycles != '0) &&
                           ((TW1'(tcnt_q) + TW1'(1)) == TW1'(timeout_cycles));

    // Lowest-indexed arrived ID, and whether any arrived ID differs from it
    always_comb begin
        first_id_c    = '0;
        first_found_c = 1'b0;
        mismatch_c    = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (arrived_q[i]) begin
                if (!first_found_c) begin
                    first_id_c    = ids_q[i*IW +: IW];
                    first_found_c = 1'b1;
                end else if (ids_q[i*IW +: IW] != first_id_c) begin
                    mismatch_c = 1'b1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an arrival during RELEASE opens the next round directly
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|start_hits_c) state_d = COLLECT;
            COLLECT: if (all_arrived_c || timeout_hit_c) state_d = RELEASE;
            RELEASE: state_d = (|start_hits_c) ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        arrived_d = arrived_q;
        mask_d    = mask_q;
        ids_d     = ids_q;
        tcnt_d    = tcnt_q;
        load_c    = '0;
        ready_d   = '0;
        last_id_d = last_barrier_id;
        count_d   = release_count;
        set_mis_c = 1'b0;
        set_dup_c = 1'b0;
        set_to_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|start_hits_c) begin
                    mask_d    = core_mask;
                    arrived_d = start_hits_c;
                    load_c    = start_hits_c;
                    tcnt_d    = '0;
                end
            end
            COLLECT: begin
                load_c    = sync_enable & mask_q & ~arrived_q;
                arrived_d = arrived_q | load_c;
                set_dup_c = |(sync_enable & mask_q & arrived_q);
                if (!all_arrived_c) begin
                    tcnt_d   = tcnt_q + TIMEOUT_WIDTH'(1);
                    set_to_c = timeout_hit_c;
                end
            end
            RELEASE: begin
                ready_d   = arrived_q;
                last_id_d = first_id_c;
                count_d   = release_count + COUNT_WIDTH'(1);
                set_mis_c = mismatch_c;
                tcnt_d    = '0;
                // Flags clear, then any same-cycle arrival seeds the next round
                arrived_d = start_hits_c;
                load_c    = start_hits_c;
                if (|start_hits_c) begin
                    mask_d = core_mask;
                end
            end
            default: begin
                arrived_d = '0;
                tcnt_d    = '0;
            end
        endcase

        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (load_c[i]) begin
                ids_d[i*IW +: IW] = sync_barrier[i*IW +: IW];
            end
        end

        busy_d = (state_d != IDLE);

        // Clear only drops held errors; a fresh error in the same cycle still sets
        err_mismatch_d = set_mis_c | (err_mismatch & ~err_clear);
        err_dup_d      = set_dup_c | (err_dup      & ~err_clear);
        err_timeout_d  = set_to_c  | (err_timeout  & ~err_clear);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arrived_q       <= '0;
            mask_q          <= '0;
            ids_q           <= '0;
            tcnt_q          <= '0;
            sync_ready      <= '0;
            busy            <= 1'b0;
            last_barrier_id <= '0;
            release_count   <= '0;
            err_mismatch    <= 1'b0;
            err_dup         <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            arrived_q       <= arrived_d;
            mask_q          <= mask_d;
            ids_q           <= ids_d;
            tcnt_q          <= tcnt_d;
            sync_ready      <= ready_d;
            busy            <= busy_d;
            last_barrier_id <= last_id_d;
            release_count   <= count_d;
            err_mismatch    <= err_mismatch_d;
            err_dup         <= err_dup_d;
            err_timeout     <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Self-checking bench for sync_barrier_ctrl: directed scenarios followed by
// randomized barrier rounds checked against a round-level reference model.
module tb_sync_barrier_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    core_mask;
    logic [15:0]     timeout_cycles;
    logic [N-1:0]    sync_enable;
    logic [N*IW-1:0] sync_barrier;
    logic [N-1:0]    sync_ready;
    logic            busy;
    logic [IW-1:0]   last_barrier_id;
    logic [15:0]     release_count;
    logic            err_clear;
    logic            err_mismatch;
    logic            err_dup;
    logic            err_timeout;

    int vectors;
    int miscompares;
    int exp_count;

    sync_barrier_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .core_mask       (core_mask),
        .timeout_cycles  (timeout_cycles),
        .sync_enable     (sync_enable),
        .sync_barrier    (sync_barrier),
        .sync_ready      (sync_ready),
        .busy            (busy),
        .last_barrier_id (last_barrier_id),
        .release_count   (release_count),
        .err_clear       (err_clear),
        .err_mismatch    (err_mismatch),
        .err_dup         (err_dup),
        .err_timeout     (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick n cycles, requiring that no release strobe appears
    task automatic idle(input int n, input string tag);
        logic [N-1:0] acc;
        acc = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            acc |= sync_ready;
        end
        chk(tag, 32'(acc), 32'h0);
    endtask

    // One-cycle arrival strobe on the given cores, all carrying the given ID
    task automatic pulse(input logic [N-1:0] en, input logic [IW-1:0] id);
        sync_enable  = en;
        sync_barrier = {N{id}};
        tick();
        sync_enable = '0;
    endtask

    // Wait (bounded) for the release strobe; lat counts edges, -1 on expiry
    task automatic wait_release(input int budget, output logic [N-1:0] rdy, output int lat);
        rdy = '0;
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (sync_ready != '0) begin
                rdy = sync_ready;
                lat = k;
                break;
            end
        end
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    initial begin
        logic [N-1:0]  rdy;
        int            lat;
        logic [N-1:0]  rmask;
        logic [IW-1:0] rids [N];
        int            toff [N];
        int            tmin, tmax;
        logic [N-1:0]  en, acc;
        logic [IW-1:0] exp_id;
        logic          exp_mis;
        bit            have_first;

        vectors = 0; miscompares = 0; exp_count = 0;
        reset = 1'b0; core_mask = '0; timeout_cycles = '0;
        sync_enable = '0; sync_barrier = '0; err_clear = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(sync_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(release_count), 32'h0);
        chk("rst_errs", 32'({err_mismatch, err_dup, err_timeout}), 32'h0);
        reset = 1'b1;
        tick();

        // Full mask, staggered arrivals with a common ID
        core_mask = 4'b1111;
        pulse(4'b0001, 8'h05);
        chk("t1_busy", 32'(busy), 32'h1);
        idle(1, "t1_early0");
        pulse(4'b0010, 8'h05);
        idle(2, "t1_early1");
        pulse(4'b0100, 8'h05);
        idle(4, "t1_early2");
        pulse(4'b1000, 8'h05);
        wait_release(10, rdy, lat);
        exp_count++;
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_ready", 32'(rdy), 32'hF);
        chk("t1_id", 32'(last_barrier_id), 32'h05);
        chk("t1_count", 32'(release_count), 32'(exp_count));
        chk("t1_errs", 32'({err_mismatch, err_dup, err_timeout}), 32'h0);
        tick();
        chk("t1_pulse_width", 32'(sync_ready), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // Unmasked core enabling alongside masked ones is ignored
        core_mask = 4'b0101;
        pulse(4'b0111, 8'h3A);
        wait_release(10, rdy, lat);
        exp_count++;
        chk("t2_lat", 32'(lat), 32'd2);
        chk("t2_ready", 32'(rdy), 32'h5);
        chk("t2_id", 32'(last_barrier_id), 32'h3A);
        chk("t2_count", 32'(release_count), 32'(exp_count));
        chk("t2_errs", 32'({err_mismatch, err_dup, err_timeout}), 32'h0);
        tick();

        // Differing IDs still release, and flag a mismatch
        core_mask = 4'b0011;
        pulse(4'b0001, 8'h01);
        pulse(4'b0010, 8'h02);
        wait_release(10, rdy, lat);
        exp_count++;
        chk("t3_ready", 32'(rdy), 32'h3);
        chk("t3_mismatch", 32'(err_mismatch), 32'h1);
        chk("t3_id", 32'(last_barrier_id), 32'h01);
        clear_errors();
        chk("t3_cleared", 32'(err_mismatch), 32'h0);

        // Timeout with only core 0 present
        timeout_cycles = 16'd8;
        core_mask = 4'b0011;
        pulse(4'b0001, 8'h11);
        wait_release(30, rdy, lat);
        exp_count++;
        chk("t4_lat", 32'(lat), 32'd9);
        chk("t4_ready", 32'(rdy), 32'h1);
        chk("t4_timeout", 32'(err_timeout), 32'h1);
        chk("t4_count", 32'(release_count), 32'(exp_count));
        timeout_cycles = '0;
        clear_errors();
        chk("t4_cleared", 32'(err_timeout), 32'h0);

        // Duplicate arrival keeps the first ID; arrival during RELEASE is kept
        core_mask = 4'b0011;
        pulse(4'b0001, 8'h07);
        pulse(4'b0001, 8'h09);
        chk("t5_dup", 32'(err_dup), 32'h1);
        pulse(4'b0010, 8'h07);
        tick();
        chk("t5_release_busy", 32'(busy), 32'h1);
        chk("t5_not_yet", 32'(sync_ready), 32'h0);
        pulse(4'b0001, 8'h21);
        exp_count++;
        chk("t5_ready", 32'(sync_ready), 32'h3);
        chk("t5_id", 32'(last_barrier_id), 32'h07);
        chk("t5_mismatch", 32'(err_mismatch), 32'h0);
        chk("t5_busy_kept", 32'(busy), 32'h1);
        pulse(4'b0010, 8'h21);
        wait_release(10, rdy, lat);
        exp_count++;
        chk("t5b_lat", 32'(lat), 32'd2);
        chk("t5b_ready", 32'(rdy), 32'h3);
        chk("t5b_id", 32'(last_barrier_id), 32'h21);
        chk("t5b_count", 32'(release_count), 32'(exp_count));

        // Reset mid-COLLECT aborts the round immediately
        core_mask = 4'b1111;
        pulse(4'b0001, 8'h55);
        tick();
        reset = 1'b0;
        #2;
        chk("t6_ready", 32'(sync_ready), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_count", 32'(release_count), 32'h0);
        chk("t6_id", 32'(last_barrier_id), 32'h0);
        chk("t6_errs", 32'({err_mismatch, err_dup, err_timeout}), 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        exp_count = 0;
        idle(3, "t6_no_release");
        core_mask = 4'b0011;
        pulse(4'b0011, 8'h44);
        wait_release(10, rdy, lat);
        exp_count++;
        chk("t6b_lat", 32'(lat), 32'd2);
        chk("t6b_ready", 32'(rdy), 32'h3);
        chk("t6b_count", 32'(release_count), 32'(exp_count));
        tick();

        // Randomized rounds against the round-level model
        for (int r = 0; r < 24; r++) begin
            clear_errors();
            rmask = N'($urandom_range(1, 15));
            tmin = 100;
            tmax = 0;
            for (int i = 0; i < N; i++) begin
                rids[i] = IW'($urandom);
                toff[i] = $urandom_range(0, 6);
                if (rmask[i] && toff[i] < tmin) tmin = toff[i];
            end
            if (r % 2 == 0) begin
                for (int i = 1; i < N; i++) rids[i] = rids[0];
            end
            for (int i = 0; i < N; i++) begin
                toff[i] = toff[i] - tmin;
                if (rmask[i] && toff[i] > tmax) tmax = toff[i];
            end
            // Expected: lowest masked core's ID; mismatch if any masked ID differs
            have_first = 1'b0;
            exp_id  = '0;
            exp_mis = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (rmask[i]) begin
                    if (!have_first) begin
                        exp_id = rids[i];
                        have_first = 1'b1;
                    end else if (rids[i] != exp_id) begin
                        exp_mis = 1'b1;
                    end
                end
            end
            acc = '0;
            for (int c = 0; c <= tmax; c++) begin
                en = N'($urandom) & ~rmask;
                for (int i = 0; i < N; i++) begin
                    if (rmask[i] && toff[i] == c) en[i] = 1'b1;
                end
                core_mask   = (c == 0) ? rmask : N'($urandom);
                sync_enable = en;
                for (int i = 0; i < N; i++) sync_barrier[i*IW +: IW] = rids[i];
                tick();
                acc |= sync_ready;
            end
            sync_enable = '0;
            core_mask   = '0;
            chk($sformatf("r%0d_early", r), 32'(acc), 32'h0);
            wait_release(10, rdy, lat);
            exp_count++;
            chk($sformatf("r%0d_lat", r), 32'(lat), 32'd2);
            chk($sformatf("r%0d_ready", r), 32'(rdy), 32'(rmask));
            chk($sformatf("r%0d_id", r), 32'(last_barrier_id), 32'(exp_id));
            chk($sformatf("r%0d_mis", r), 32'(err_mismatch), 32'(exp_mis));
            chk($sformatf("r%0d_dup", r), 32'(err_dup), 32'h0);
            chk($sformatf("r%0d_count", r), 32'(release_count), 32'(exp_count));
            tick();
            chk($sformatf("r%0d_idle", r), 32'({busy, sync_ready}), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_barrier_ctrl.md
Name: sync_barrier_ctrl

Overview:
- Responder end of the sync interface: terminates `sync.barrier`/`sync.enable` from N_CORES distributed processor cores and drives each core's `sync.ready`.
- Collects barrier arrivals. When every participating core has arrived, it releases them all in the same cycle.
- Sits at the top level beside the `proc` instances. One `sync_iface` per core is flattened onto the ports below.
- Flags mismatched barrier IDs, duplicate arrivals and timeouts.

Parameters:
- N_CORES, 4, number of attached cores.
- SYNC_BARRIER_WIDTH, 8, barrier ID width per core.
- TIMEOUT_WIDTH, 16, width of the timeout counter and `timeout_cycles` port.
- COUNT_WIDTH, 16, width of the release counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset; 0 = reset.
- core_mask  in  N_CORES  participating cores; sampled at the first arrival of each round.
- timeout_cycles  in  TIMEOUT_WIDTH  round timeout in cycles; 0 disables the timeout.
- sync_enable  in  N_CORES  per-core arrival strobe, 1 cycle.
- sync_barrier  in  N_CORES*SYNC_BARRIER_WIDTH  per-core barrier ID; core i uses bits [i*W +: W].
- sync_ready  out  N_CORES  per-core release strobe.
- busy  out  1  a round is in progress.
- last_barrier_id  out  SYNC_BARRIER_WIDTH  ID of the most recent release.
- release_count  out  COUNT_WIDTH  number of releases.
- err_clear  in  1  clears all sticky errors.
- err_mismatch  out  1  sticky: arrived IDs differed.
- err_dup  out  1  sticky: a core arrived twice in one round.
- err_timeout  out  1  sticky: round timed out.

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; arrival flags, stored IDs, mask latch and timeout counter cleared.
- States: IDLE, COLLECT, RELEASE.
- IDLE:
  - Any `sync_enable[i]` with `core_mask[i]=1` latches `core_mask` into `mask_q`, sets `arrived[i]`, stores the ID and goes to COLLECT.
  - Enables from unmasked cores are ignored; those cores are never released.
  - `core_mask=0` keeps the block in IDLE.
- COLLECT:
  - Each enable from an unarrived core in `mask_q` sets its flag and stores its ID.
  - An enable from an already-arrived core sets `err_dup`; the stored ID is unchanged.
  - `core_mask` changes are ignored until the next round.
  - When `arrived==mask_q` (registered flags), the next edge enters RELEASE.
  - Each COLLECT cycle increments the timeout counter. When the counter reaches `timeout_cycles` (and `timeout_cycles` is nonzero), set `err_timeout` and enter RELEASE with the current `arrived` set.
- RELEASE (1 cycle):
  - `sync_ready = arrived` (registered output).
  - `last_barrier_id` = stored ID of the lowest-indexed arrived core.
  - If any arrived IDs differ, set `err_mismatch`; release still occurs so cores do not deadlock.
  - Increment `release_count` (wraps at 2^COUNT_WIDTH).
  - Clear flags and the timeout counter; next state IDLE.
  - An enable sampled during RELEASE starts the next round: the flag is set after the clear, then go to COLLECT. It is not lost.
- Latency: `sync_ready` is high for exactly 1 cycle, starting 2 edges after the edge that sampled the final arrival.
- `busy` = 1 in COLLECT and RELEASE.
- Simultaneous enables from several cores in the same cycle are all registered.
- `err_clear` has priority over a same-cycle error set only for errors already held; a new error in that cycle still sets.
- Reset mid-round aborts the round; no `sync_ready` is issued.

Test Plan:
- Mask=4'b1111, cores 0..3 enable with ID 0x05 on cycles 10, 12, 15, 20 -> `sync_ready=4'b1111` for 1 cycle at cycle 22; `last_barrier_id=0x05`; `release_count=1`; no errors.
- Mask=4'b0101, cores 0 and 2 enable together with ID 0x3A, core 1 also enables -> `sync_ready=4'b0101` 2 cycles later; core 1 is never readied.
- Mask=4'b0011, core 0 ID 0x01, core 1 ID 0x02 -> release `4'b0011`; `err_mismatch=1`; `last_barrier_id=0x01`; `err_clear` pulse -> 0.
- `timeout_cycles=8`, mask=4'b0011, only core 0 arrives -> `err_timeout=1`; `sync_ready=4'b0001` after 8 COLLECT cycles.
- Core 0 enables twice before core 1 arrives -> `err_dup=1`; single release `4'b0011`. A core 0 enable during the RELEASE cycle -> `busy` stays 1 and the next round shows core 0 arrived.
- `reset`=0 asserted mid-COLLECT -> all outputs 0 immediately; after deassert, a full round releases normally with `release_count=1`.
